video_mem_arbiter: RTL and testbench

VIDEO_MEM_ARBITER -- requirements
Module: video_mem_arbiter

---
 rtl/video_mem_arbiter_if.sv | 37 +++
 rtl/video_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_video_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/video_mem_arbiter_if.sv
// Video / CPU request ports and SRAM pins of the video memory arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface video_mem_arbiter_if;
    logic        vid_req;
    logic        vid_req_is_up;
    logic [14:0] vid_addr;
    logic        screen_page;
    logic        vid_ack;
    logic        vid_data_valid;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_in;
    logic        sram_oe_n;
    logic        sram_we_n;

    modport slave (
        input  vid_req, vid_req_is_up, vid_addr, screen_page,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_dq_in,
        output vid_ack, vid_data_valid, vid_data, cpu_rdata, cpu_ack,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_oe_n, sram_we_n
    );

    modport master (
        output vid_req, vid_req_is_up, vid_addr, screen_page,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_dq_in,
        input  vid_ack, vid_data_valid, vid_data, cpu_rdata, cpu_ack,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/video_mem_arbiter.sv
// Shares one async SRAM between video fetch and the CPU using fixed 4-cycle
// accesses (T0..T3); ties alternate, so video gets a slot at least every 8 cycles.
module video_mem_arbiter #(
    parameter logic [18:0] UP_BASE = 19'h7FFC0
) (
    input  logic                 clk28,
    input  logic                 rst_n,
    video_mem_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_cpu;
    logic        r_we;
    logic        w_arb_window;
    logic        w_cpu_req_eff;
    logic        w_grant_vid;
    logic        w_grant_cpu;
    logic        w_grant_any;
    logic        w_busy_next;
    logic        w_we_next;
    logic        w_end_access;
    logic [18:0] w_vid_addr_phys;
    logic        w_vid_addr_unused;

    logic        r_vid_ack;
    logic        r_vid_valid;
    logic [7:0]  r_vid_data;
    logic        r_cpu_ack;
    logic [7:0]  r_cpu_rdata;
    logic [18:0] r_sram_addr;
    logic [7:0]  r_dq_out;
    logic        r_dq_oe;
    logic        r_oe_n;
    logic        r_we_n;

    // The CPU request being served is still high at its own T3; it must not win again there.
    always_comb begin
        w_arb_window  = (r_state == ST_IDLE) || (r_state == ST_T3);
        w_cpu_req_eff = bus.cpu_req && !((r_state == ST_T3) && r_last_cpu);
        w_grant_vid   = 1'b0;
        w_grant_cpu   = 1'b0;
        if (w_arb_window) begin
            if (bus.vid_req && w_cpu_req_eff) begin
                w_grant_vid = r_last_cpu;
                w_grant_cpu = ~r_last_cpu;
            end else begin
                w_grant_vid = bus.vid_req;
                w_grant_cpu = w_cpu_req_eff;
            end
        end else begin
            w_grant_vid = 1'b0;
            w_grant_cpu = 1'b0;
        end
        w_grant_any = w_grant_vid | w_grant_cpu;
    end

    // Next-state logic of the access sequencer
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next_state = w_grant_any ? ST_T0 : ST_IDLE;
            ST_T0:   w_next_state = ST_T1;
            ST_T1:   w_next_state = ST_T2;
            ST_T2:   w_next_state = ST_T3;
            ST_T3:   w_next_state = w_grant_any ? ST_T0 : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Physical address of a video fetch: screen page 5/7 or palette entry
    always_comb begin
        w_vid_addr_phys = 19'd0;
        if (bus.vid_req_is_up) begin
            w_vid_addr_phys = UP_BASE + {13'd0, bus.vid_addr[5:0]};
        end else begin
            w_vid_addr_phys = {(bus.screen_page ? 5'd7 : 5'd5), bus.vid_addr[13:0]};
        end
    end

    assign w_busy_next       = (w_next_state != ST_IDLE);
    assign w_we_next         = w_grant_any ? (w_grant_cpu & bus.cpu_we) : r_we;
    assign w_end_access      = (r_state == ST_T3);
    assign w_vid_addr_unused = bus.vid_addr[14];

    // State register plus owner/direction of the access in flight
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last_cpu <= 1'b1;
            r_we       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_any) begin
                r_last_cpu <= w_grant_cpu;
                r_we       <= w_grant_cpu & bus.cpu_we;
            end
        end
    end

    // Strobes are registered from the next state so they are glitch-free on the pins.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_sram_addr <= 19'd0;
            r_dq_out    <= 8'd0;
            r_vid_data  <= 8'd0;
            r_cpu_rdata <= 8'd0;
        end else begin
            r_oe_n      <= ~(w_busy_next & ~w_we_next);
            r_dq_oe     <= w_busy_next & w_we_next;
            r_we_n      <= ~(w_we_next & ((w_next_state == ST_T1) || (w_next_state == ST_T2)));
            r_vid_ack   <= w_grant_vid;
            r_vid_valid <= w_end_access & ~r_last_cpu;
            r_cpu_ack   <= w_end_access & r_last_cpu;
            if (w_grant_vid) begin
                r_sram_addr <= w_vid_addr_phys;
            end else if (w_grant_cpu) begin
                r_sram_addr <= bus.cpu_addr;
                r_dq_out    <= bus.cpu_wdata;
            end
            if (w_end_access && !r_last_cpu) begin
                r_vid_data <= bus.sram_dq_in;
            end
            if (w_end_access && r_last_cpu && !r_we) begin
                r_cpu_rdata <= bus.sram_dq_in;
            end
        end
    end

    assign bus.vid_ack        = r_vid_ack;
    assign bus.vid_data_valid = r_vid_valid;
    assign bus.vid_data       = r_vid_data;
    assign bus.cpu_ack        = r_cpu_ack;
    assign bus.cpu_rdata      = r_cpu_rdata;
    assign bus.sram_addr      = r_sram_addr;
    assign bus.sram_dq_out    = r_dq_out;
    assign bus.sram_dq_oe     = r_dq_oe;
    assign bus.sram_oe_n      = r_oe_n;
    assign bus.sram_we_n      = r_we_n;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Scoreboard bench for video_mem_arbiter: directed stimulus pushes expected
// addresses/data; a negedge monitor pops and compares on every ack/valid pulse.
module tb_video_mem_arbiter;

    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    video_mem_arbiter_if bus();

    video_mem_arbiter #(.UP_BASE(19'h7FFC0)) dut (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk28 = ~clk28;
    always @(posedge clk28) cyc++;

    logic [31:0] q_vaddr[$];
    logic [31:0] q_vdata[$];
    logic [31:0] q_cdata[$];
    int          q_ack_cyc[$];
    int          ack_log[$];
    bit          q_order[$];   // 0 = video completion, 1 = CPU completion

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk28);
        #1;
    endtask

    // SRAM model: data is only valid during the 4th cycle of a read, so an early sample sees 8'hEE.
    logic [1:0] ph = 2'd0;
    bit         prev_low = 1'b0;
    always @(negedge clk28) begin
        if (!bus.sram_oe_n) begin
            ph       = prev_low ? ph + 2'd1 : 2'd0;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
        bus.sram_dq_in = (!bus.sram_oe_n && ph == 2'd3) ? (bus.sram_addr[7:0] ^ 8'h5A) : 8'hEE;
    end

    // Monitor
    always @(negedge clk28) begin
        if (bus.vid_ack) begin
            ack_log.push_back(cyc);
            q_ack_cyc.push_back(cyc);
            if (q_vaddr.size() == 0) check("unexpected_vid_ack", 32'd1, 32'd0);
            else check("vid_sram_addr", 32'(bus.sram_addr), q_vaddr.pop_front());
        end
        if (bus.vid_data_valid) begin
            q_order.push_back(1'b0);
            if (q_vdata.size() == 0) check("unexpected_vid_valid", 32'd1, 32'd0);
            else check("vid_data", 32'(bus.vid_data), q_vdata.pop_front());
            if (q_ack_cyc.size() != 0) check("valid_after_ack", 32'(cyc - q_ack_cyc.pop_front()), 32'd4);
        end
        if (bus.cpu_ack) begin
            q_order.push_back(1'b1);
            if (q_cdata.size() == 0) check("unexpected_cpu_ack", 32'd1, 32'd0);
            else check("cpu_rdata", 32'(bus.cpu_rdata), q_cdata.pop_front());
        end
    end

    task automatic drain(input string name);
        for (int k = 0; k < 30; k++) begin
            if (q_vaddr.size() + q_vdata.size() + q_cdata.size() == 0) break;
            tick();
        end
        check(name, 32'(q_vaddr.size() + q_vdata.size() + q_cdata.size()), 32'd0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        q_ack_cyc.delete();
    endtask

    initial begin
        int          n;
        int          c1;
        logic [4:0]  v_oe, v_we, v_oen, v_ack;
        logic [4:0]  ord;

        bus.vid_req = 1'b0; bus.vid_req_is_up = 1'b0; bus.vid_addr = 15'd0; bus.screen_page = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 19'd0; bus.cpu_wdata = 8'd0;
        bus.sram_dq_in = 8'hEE;

        // Reset values while rst_n is held low
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_dq_out", 32'(bus.sram_dq_out), 32'd0);
        check("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_vid_ack", 32'(bus.vid_ack), 32'd0);
        check("rst_vid_valid", 32'(bus.vid_data_valid), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_vid_data", 32'(bus.vid_data), 32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("idle_oe_n", 32'(bus.sram_oe_n), 32'd1);
        check("idle_we_n", 32'(bus.sram_we_n), 32'd1);

        // Video screen reads: page 7, offset 0x0123 -> 0x1C123, data 0x23^0x5A
        ack_log.delete();
        repeat (3) begin q_vaddr.push_back(32'h1C123); q_vdata.push_back(32'h79); end
        bus.screen_page = 1'b1; bus.vid_addr = 15'h4123; bus.vid_req = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            tick();
            if (bus.vid_ack) n++;
        end
        bus.vid_req = 1'b0;
        check("vid_ack_count", 32'(n), 32'd3);
        drain("vid_drain");
        if (ack_log.size() >= 3) begin
            check("vid_ack_period0", 32'(ack_log[1] - ack_log[0]), 32'd4);
            check("vid_ack_period1", 32'(ack_log[2] - ack_log[1]), 32'd4);
        end else begin
            check("vid_ack_log_size", 32'(ack_log.size()), 32'd3);
        end
        check("vid_data_held", 32'(bus.vid_data), 32'h79);

        // Palette read: index 0x2A -> 0x7FFC0 + 0x2A, upper vid_addr bits ignored
        q_vaddr.push_back(32'h7FFEA); q_vdata.push_back(32'hB0);
        bus.vid_req_is_up = 1'b1; bus.vid_addr = 15'h7FEA; bus.vid_req = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 1; k++) begin
            tick();
            if (bus.vid_ack) n++;
        end
        bus.vid_req = 1'b0; bus.vid_req_is_up = 1'b0;
        check("pal_ack_count", 32'(n), 32'd1);
        drain("pal_drain");

        // Tie from reset: video first, then strict V,C,V,C alternation
        do_reset();
        ack_log.delete(); q_order.delete();
        repeat (3) begin q_vaddr.push_back(32'h14040); q_vdata.push_back(32'h1A); end
        repeat (2) q_cdata.push_back(32'h1F);
        bus.screen_page = 1'b0; bus.vid_addr = 15'h0040; bus.vid_req = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 19'h12345; bus.cpu_req = 1'b1;
        n = 0; c1 = 0;
        for (int k = 0; k < 60 && n < 2; k++) begin
            tick();
            if (bus.cpu_ack) begin
                n++;
                if (n == 1) c1 = cyc;
            end
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        check("tie_cpu_ack_count", 32'(n), 32'd2);
        drain("tie_drain");
        if (ack_log.size() != 0) check("tie_cpu_ack_cycle", 32'(c1 - ack_log[0] + 1), 32'd9);
        else check("tie_first_vid_ack", 32'd0, 32'd1);
        check("tie_order_len", 32'(q_order.size()), 32'd5);
        ord = 5'd0;
        for (int i = 0; i < 5 && i < q_order.size(); i++) ord[4 - i] = q_order[i];
        check("tie_order", 32'(ord), 32'h0A);

        // CPU write: strobe shape over T0..T3 and the ack cycle; late input changes ignored
        q_cdata.push_back(32'h1F);
        bus.cpu_we = 1'b1; bus.cpu_addr = 19'h00ABC; bus.cpu_wdata = 8'hA5; bus.cpu_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            v_oe[4 - k]  = bus.sram_dq_oe;
            v_we[4 - k]  = bus.sram_we_n;
            v_oen[4 - k] = bus.sram_oe_n;
            v_ack[4 - k] = bus.cpu_ack;
            if (k == 0) begin
                check("wr_sram_addr", 32'(bus.sram_addr), 32'h00ABC);
                check("wr_dq_out", 32'(bus.sram_dq_out), 32'hA5);
            end
            if (k == 1) begin
                bus.cpu_addr = 19'h55555; bus.cpu_wdata = 8'h00;
            end
            if (k == 2) begin
                check("wr_addr_stable", 32'(bus.sram_addr), 32'h00ABC);
                check("wr_data_stable", 32'(bus.sram_dq_out), 32'hA5);
            end
        end
        bus.cpu_req = 1'b0;
        check("wr_dq_oe_shape", 32'(v_oe), 32'h1E);
        check("wr_we_n_shape", 32'(v_we), 32'h13);
        check("wr_oe_n_shape", 32'(v_oen), 32'h1F);
        check("wr_ack_shape", 32'(v_ack), 32'h01);
        drain("wr_drain");
        repeat (3) tick();

        // Reset during T2 of a write aborts it; the held request then completes
        bus.cpu_we = 1'b1; bus.cpu_addr = 19'h00123; bus.cpu_wdata = 8'h3C; bus.cpu_req = 1'b1;
        repeat (3) tick();
        check("mid_we_n_before", 32'(bus.sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_we_n_async", 32'(bus.sram_we_n), 32'd1);
        check("mid_dq_oe_async", 32'(bus.sram_dq_oe), 32'd0);
        tick();
        check("mid_cpu_rdata_rst", 32'(bus.cpu_rdata), 32'd0);
        check("mid_sram_addr_rst", 32'(bus.sram_addr), 32'd0);
        q_cdata.push_back(32'h00);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 10 && n == 0; k++) begin
            tick();
            if (k == 1) check("mid_dq_out", 32'(bus.sram_dq_out), 32'h3C);
            if (bus.cpu_ack) n = k;
        end
        bus.cpu_req = 1'b0;
        check("mid_ack_latency", 32'(n), 32'd5);
        drain("mid_drain");
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
